// File: rtl/dpic_perf_cache_counter.sv
// rtl/dpic_perf_cache_counter.sv - per-(channel, access type) saturating cache event counters
// A dump FSM snapshots each counter in turn and streams it out, optionally clearing it.
`timescale 1ns/1ps
module dpic_perf_cache_counter #(
  parameter int NUM_CH    = 2,
  parameter int NUM_TYPES = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ev_valid,
  input  logic [NUM_CH*8-1:0]  ev_type,
  input  logic                 clr,
  input  logic                 dump_start,
  input  logic                 clear_on_dump,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [7:0]           dump_ch,
  output logic [7:0]           dump_type,
  output logic [CNT_WIDTH-1:0] dump_count,
  output logic                 dump_last,
  output logic                 busy,
  output logic                 sat_any,
  output logic                 err_type
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TY_W = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_PEN = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [TY_W-1:0] TY_LAST = TY_W'(NUM_TYPES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_e;

  state_e                 state_q;
  logic [CH_W-1:0]        ch_idx_q;
  logic [TY_W-1:0]        ty_idx_q;
  logic                   cod_q;
  logic                   busy_q;
  logic                   dump_valid_q;
  logic [7:0]             dump_ch_q;
  logic [7:0]             dump_type_q;
  logic [CNT_WIDTH-1:0]   dump_count_q;
  logic                   dump_last_q;

  logic [CNT_WIDTH-1:0]   cnt_q [NUM_CH][NUM_TYPES];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_CH][NUM_TYPES];
  logic [NUM_CH-1:0][NUM_TYPES-1:0] hit;
  logic [NUM_CH-1:0]      ev_bad;
  logic                   sat_hit;
  logic                   sat_q, sat_d;
  logic                   err_q, err_d;

  assign dump_valid = dump_valid_q;
  assign dump_ch    = dump_ch_q;
  assign dump_type  = dump_type_q;
  assign dump_count = dump_count_q;
  assign dump_last  = dump_last_q;
  assign busy       = busy_q;
  assign sat_any    = sat_q;
  assign err_type   = err_q;

  always_comb begin
    hit    = '0;
    ev_bad = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ev_bad[k] = ev_valid[k] && ({1'b0, ev_type[8*k +: 8]} >= 9'(NUM_TYPES));
      for (int t = 0; t < NUM_TYPES; t++) begin
        hit[k][t] = ev_valid[k] && (ev_type[8*k +: 8] == 8'(t));
      end
    end
  end

  // Priority per counter: clr, then clear-on-dump reload (keeps a same-cycle event), then increment.
  always_comb begin
    sat_hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        cnt_d[k][t] = cnt_q[k][t];
        if (clr) begin
          cnt_d[k][t] = '0;
        end else if ((state_q == ST_LOAD) && cod_q &&
                     (ch_idx_q == CH_W'(k)) && (ty_idx_q == TY_W'(t))) begin
          cnt_d[k][t] = hit[k][t] ? CNT_ONE : '0;
        end else if (hit[k][t] && (cnt_q[k][t] != CNT_MAX)) begin
          cnt_d[k][t] = cnt_q[k][t] + CNT_ONE;
          if (cnt_q[k][t] == CNT_PEN) begin
            sat_hit = 1'b1;
          end
        end
      end
    end
  end

  assign sat_d = clr ? 1'b0 : (sat_q | sat_hit);
  assign err_d = clr ? 1'b0 : (err_q | (|ev_bad));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        for (int t = 0; t < NUM_TYPES; t++) begin
          cnt_q[k][t] <= '0;
        end
      end
      sat_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        for (int t = 0; t < NUM_TYPES; t++) begin
          cnt_q[k][t] <= cnt_d[k][t];
        end
      end
      sat_q <= sat_d;
      err_q <= err_d;
    end
  end

  // Type index moves fastest; entries are held in SEND until the sink takes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ch_idx_q     <= '0;
      ty_idx_q     <= '0;
      cod_q        <= 1'b0;
      busy_q       <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_ch_q    <= '0;
      dump_type_q  <= '0;
      dump_count_q <= '0;
      dump_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dump_start) begin
            state_q  <= ST_LOAD;
            ch_idx_q <= '0;
            ty_idx_q <= '0;
            cod_q    <= clear_on_dump;
            busy_q   <= 1'b1;
          end
        end
        ST_LOAD: begin
          dump_count_q <= cnt_q[ch_idx_q][ty_idx_q];
          dump_ch_q    <= 8'(ch_idx_q);
          dump_type_q  <= 8'(ty_idx_q);
          dump_last_q  <= (ch_idx_q == CH_LAST) && (ty_idx_q == TY_LAST);
          dump_valid_q <= 1'b1;
          state_q      <= ST_SEND;
        end
        ST_SEND: begin
          if (dump_ready) begin
            dump_valid_q <= 1'b0;
            if (dump_last_q) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_LOAD;
              if (ty_idx_q == TY_LAST) begin
                ty_idx_q <= '0;
                ch_idx_q <= ch_idx_q + CH_W'(1);
              end else begin
                ty_idx_q <= ty_idx_q + TY_W'(1);
              end
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          dump_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpic_perf_cache_counter.sv
// tb/tb_dpic_perf_cache_counter.sv - scoreboard bench for dpic_perf_cache_counter
// Two instances share stimulus: default 32-bit counters and 4-bit counters for saturation.
`timescale 1ns/1ps
module tb_dpic_perf_cache_counter;
  localparam int NCH = 2;
  localparam int NTY = 4;
  localparam int MAXB = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NCH-1:0]   ev_valid = '0;
  logic [NCH*8-1:0] ev_type = '0;
  logic             clr = 1'b0;
  logic             dump_start = 1'b0;
  logic             clear_on_dump = 1'b0;
  logic             dump_ready = 1'b1;

  logic        dump_valid_a, dump_last_a, busy_a, sat_any_a, err_type_a;
  logic [7:0]  dump_ch_a, dump_type_a;
  logic [31:0] dump_count_a;
  logic        dump_valid_b, dump_last_b, busy_b, sat_any_b, err_type_b;
  logic [7:0]  dump_ch_b, dump_type_b;
  logic [3:0]  dump_count_b;

  always #5 clk = ~clk;

  dpic_perf_cache_counter #(.NUM_CH(NCH), .NUM_TYPES(NTY), .CNT_WIDTH(32)) u_dut_a (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_type(ev_type), .clr(clr),
    .dump_start(dump_start), .clear_on_dump(clear_on_dump), .dump_valid(dump_valid_a),
    .dump_ready(dump_ready), .dump_ch(dump_ch_a), .dump_type(dump_type_a),
    .dump_count(dump_count_a), .dump_last(dump_last_a), .busy(busy_a),
    .sat_any(sat_any_a), .err_type(err_type_a)
  );

  dpic_perf_cache_counter #(.NUM_CH(NCH), .NUM_TYPES(NTY), .CNT_WIDTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_type(ev_type), .clr(clr),
    .dump_start(dump_start), .clear_on_dump(clear_on_dump), .dump_valid(dump_valid_b),
    .dump_ready(dump_ready), .dump_ch(dump_ch_b), .dump_type(dump_type_b),
    .dump_count(dump_count_b), .dump_last(dump_last_b), .busy(busy_b),
    .sat_any(sat_any_b), .err_type(err_type_b)
  );

  typedef struct {
    int     ch;
    int     ty;
    longint cnt;
    bit     last;
  } entry_t;

  entry_t sb[$];
  entry_t mon_e;
  int n_pass = 0;
  int n_checks = 0;
  int n_pops = 0;

  int m_cnt [NCH][NTY];
  int m_state = 0;
  int m_ch = 0;
  int m_ty = 0;
  bit m_cod = 0;
  bit m_sat4 = 0;
  bit m_err = 0;
  bit m_bad, m_satnew, m_hit, m_ldclr;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: counts are unbounded ints, each instance's view is clamped to its width.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++)
        for (int t = 0; t < NTY; t++) m_cnt[k][t] = 0;
      m_state = 0; m_ch = 0; m_ty = 0; m_cod = 0; m_sat4 = 0; m_err = 0;
      sb.delete();
    end else begin
      m_bad = 0;
      m_satnew = 0;
      if (m_state == 1)
        sb.push_back('{m_ch, m_ty, longint'(m_cnt[m_ch][m_ty]),
                       (m_ch == NCH-1) && (m_ty == NTY-1)});
      for (int k = 0; k < NCH; k++) begin
        if (ev_valid[k] && int'(ev_type[8*k +: 8]) >= NTY) m_bad = 1;
        for (int t = 0; t < NTY; t++) begin
          m_hit = ev_valid[k] && (int'(ev_type[8*k +: 8]) == t);
          m_ldclr = (m_state == 1) && m_cod && (k == m_ch) && (t == m_ty);
          if (clr) m_cnt[k][t] = 0;
          else if (m_ldclr) m_cnt[k][t] = int'(m_hit);
          else if (m_hit) begin
            if (m_cnt[k][t] == MAXB - 1) m_satnew = 1;
            m_cnt[k][t] = m_cnt[k][t] + 1;
          end
        end
      end
      if (clr) begin m_sat4 = 0; m_err = 0; end
      else begin m_sat4 = m_sat4 | m_satnew; m_err = m_err | m_bad; end
      case (m_state)
        0: if (dump_start) begin m_state = 1; m_ch = 0; m_ty = 0; m_cod = clear_on_dump; end
        1: m_state = 2;
        default: if (dump_ready) begin
          if (m_ch == NCH-1 && m_ty == NTY-1) m_state = 0;
          else begin
            m_state = 1;
            if (m_ty == NTY-1) begin m_ty = 0; m_ch = m_ch + 1; end
            else m_ty = m_ty + 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check_eq("busy_a", busy_a, m_state != 0);
    check_eq("busy_b", busy_b, m_state != 0);
    check_eq("valid_a", dump_valid_a, m_state == 2);
    check_eq("valid_b", dump_valid_b, m_state == 2);
    check_eq("sat_a", sat_any_a, 0);
    check_eq("sat_b", sat_any_b, m_sat4);
    check_eq("err_a", err_type_a, m_err);
    check_eq("err_b", err_type_b, m_err);
    if (dump_valid_a) begin
      if (sb.size() == 0) check_eq("sb_size", sb.size(), 1);
      else begin
        mon_e = sb[0];
        check_eq("dump_ch", dump_ch_a, mon_e.ch);
        check_eq("dump_type", dump_type_a, mon_e.ty);
        check_eq("dump_count_a", dump_count_a, mon_e.cnt);
        check_eq("dump_count_b", dump_count_b, (mon_e.cnt > MAXB) ? MAXB : mon_e.cnt);
        check_eq("dump_last", dump_last_a, mon_e.last);
        check_eq("dump_ch_b", dump_ch_b, mon_e.ch);
        if (dump_ready) begin
          void'(sb.pop_front());
          n_pops++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ev(input int ch, input int ty, input int n);
    for (int i = 0; i < n; i++) begin
      ev_valid[ch] = 1'b1;
      ev_type[8*ch +: 8] = 8'(ty);
      step();
    end
    ev_valid[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      if (!busy_a) break;
      step();
    end
    check_eq("dump_done", busy_a, 0);
    check_eq("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 20; i++) begin
      if (dump_valid_a) break;
      step();
    end
    check_eq("valid_seen", dump_valid_a, 1);
  endtask

  task automatic do_dump(input bit cod);
    int p0;
    p0 = n_pops;
    dump_start = 1'b1;
    clear_on_dump = cod;
    step();
    dump_start = 1'b0;
    clear_on_dump = 1'b0;
    wait_idle();
    check_eq("entries", n_pops - p0, NCH*NTY);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", dump_valid_a, 0);
    check_eq("rst_count", dump_count_a, 0);
    check_eq("rst_busy", busy_a, 0);
    rst = 1'b1;
    step();

    // Basic counts and full ordered dump, then the same values again (no clear-on-dump).
    pulse_ev(0, 2, 5);
    pulse_ev(1, 0, 3);
    do_dump(1'b0);
    do_dump(1'b0);

    // Saturation of the 4-bit instance.
    pulse_clr();
    pulse_ev(0, 1, 14);
    check_eq("sat_b_before", sat_any_b, 0);
    pulse_ev(0, 1, 1);
    check_eq("sat_b_at15", sat_any_b, 1);
    pulse_ev(0, 1, 5);
    check_eq("sat_b_held", sat_any_b, 1);
    do_dump(1'b0);
    pulse_clr();
    check_eq("sat_b_clr", sat_any_b, 0);

    // Clear-on-dump with a continuous event stream on (0,0).
    pulse_ev(0, 0, 3);
    ev_valid[0] = 1'b1;
    ev_type[7:0] = 8'd0;
    do_dump(1'b1);
    do_dump(1'b0);
    ev_valid[0] = 1'b0;

    // Sink stall with events arriving.
    pulse_clr();
    pulse_ev(1, 3, 2);
    ev_valid[1] = 1'b1;
    ev_type[15:8] = 8'd3;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_valid();
    dump_ready = 1'b0;
    repeat (10) step();
    check_eq("stall_valid", dump_valid_a, 1);
    dump_ready = 1'b1;
    wait_idle();
    ev_valid[1] = 1'b0;
    do_dump(1'b0);

    // Out-of-range access type.
    pulse_clr();
    pulse_ev(1, 4, 1);
    check_eq("err_set", err_type_a, 1);
    pulse_clr();
    check_eq("err_clr", err_type_a, 0);
    do_dump(1'b0);

    // Reset in the middle of a dump.
    pulse_ev(0, 1, 3);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_valid();
    dump_ready = 1'b0;
    step();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_mid_busy", busy_a, 0);
    check_eq("rst_mid_valid", dump_valid_a, 0);
    check_eq("rst_mid_valid_b", dump_valid_b, 0);
    step();
    rst = 1'b1;
    dump_ready = 1'b1;
    step();
    do_dump(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
